// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty scheduler slice.
package pwm_pkg;

  localparam int PWM_DUTY_W = 4;

  // Requester indices into req_valid / req_ready / grant vectors
  localparam int REQ_ALU = 0;
  localparam int REQ_SPI = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RAMP = 2'd2
  } pwm_sched_state_t;

endpackage

// File: rtl/pwm_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the winner when both requesters are valid.
module pwm_rr_arb
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After a grant the pointer favours the requester that just lost
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (|grant)) begin
      ptr_d = ~grant[REQ_SPI];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Arbitrates duty requests and applies them to the PWM only at period boundaries.
// Define PWM_SCHED_RAMP_EN to step duty by one per RAMP_DIV periods instead of jumping.
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = PWM_DUTY_W,
  parameter int RAMP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [DUTY_W-1:0] req_duty0,
  input  logic [DUTY_W-1:0] req_duty1,
  output logic [1:0]        req_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  pwm_sched_state_t  state_q, state_d;
  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              period_start_q;
  logic              done_q, done_d;
  logic [1:0]        grant;
  logic              accept;
  logic              last;
  logic              arb_en;
  logic [DUTY_W-1:0] acc_duty;

  assign last = &cnt_q;

`ifdef PWM_SCHED_RAMP_EN
  localparam logic [3:0] DIV_LAST = 4'(RAMP_DIV - 1);

  logic [3:0]        div_q, div_d;
  logic [DUTY_W-1:0] duty_step;

  // A ramp always completes, so requests are held off while stepping
  assign arb_en = (state_q != RAMP);

  always_comb begin
    duty_step = duty_q;
    if (duty_q < target_q) begin
      duty_step = duty_q + DUTY_W'(1);
    end else if (duty_q > target_q) begin
      duty_step = duty_q - DUTY_W'(1);
    end
  end
`else
  assign arb_en = 1'b1;
`endif

  pwm_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .enable  (arb_en),
    .advance (accept),
    .grant   (grant)
  );

  assign accept   = |grant;
  assign acc_duty = grant[REQ_SPI] ? req_duty1 : req_duty0;
  assign target_d = accept ? acc_duty : target_q;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
`ifdef PWM_SCHED_RAMP_EN
    div_d   = accept ? 4'd0 : div_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_duty == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // The old target is applied at the boundary even if a new one lands now
        if (last) begin
`ifdef PWM_SCHED_RAMP_EN
          duty_d = duty_step;
`else
          duty_d = target_q;
`endif
          if (duty_d == target_d) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef PWM_SCHED_RAMP_EN
            state_d = RAMP;
`else
            state_d = WAIT;
`endif
          end
        end else if (accept && (acc_duty == duty_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef PWM_SCHED_RAMP_EN
      RAMP: begin
        if (last) begin
          if (div_q == DIV_LAST) begin
            div_d  = 4'd0;
            duty_d = duty_step;
            if (duty_step == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            div_d = div_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      target_q       <= '0;
      state_q        <= IDLE;
      period_start_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_q + DUTY_W'(1);
      duty_q         <= duty_d;
      target_q       <= target_d;
      state_q        <= state_d;
      period_start_q <= last;
      done_q         <= done_d;
    end
  end

`ifdef PWM_SCHED_RAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end
`endif

  assign req_ready    = grant;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler; expectations follow the build's ramp setting.
module tb_pwm_duty_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [W-1:0] req_duty0 = '0;
  logic [W-1:0] req_duty1 = '0;
  logic [1:0]   req_ready;
  logic [W-1:0] duty;
  logic         period_start;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [3:0] tb_cnt;
  logic [3:0] model_duty;

  pwm_duty_scheduler #(.DUTY_W(W), .RAMP_DIV(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_duty0    (req_duty0),
    .req_duty1    (req_duty1),
    .req_ready    (req_ready),
    .duty         (duty),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference period counter, reset together with the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 4'd0;
    else     tb_cnt <= tb_cnt + 4'd1;
  end

  typedef struct {
    logic [1:0] valid;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] exp_ready;
    logic [3:0] exp_duty;
  } job_t;

  job_t jobs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_cnt(input logic [3:0] c);
    for (int k = 0; k < 20; k++) begin
      if (tb_cnt == c) break;
      tick();
    end
  endtask

  // Present a request for one cycle, checking the combinational grant first
  task automatic apply(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] exp_rdy, input string name);
    req_valid = v;
    req_duty0 = a;
    req_duty1 = b;
    #1;
    chk({name, "_ready"}, int'(req_ready), int'(exp_rdy));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  // Observe from the accept edge until done, checking every duty change
  task automatic run_job(input string name, input logic [3:0] start, input logic [3:0] target,
                         input int exp_first_it);
    logic [3:0] prev;
    logic [3:0] exp_step;
    int changes, done_cnt, done_it, first_it, exp_changes;
    prev = start;
    changes = 0;
    done_cnt = 0;
    done_it = -1;
    first_it = -1;
`ifdef PWM_SCHED_RAMP_EN
    exp_changes = (start > target) ? int'(start - target) : int'(target - start);
`else
    exp_changes = (start != target) ? 1 : 0;
`endif
    for (int it = 0; it < 400; it++) begin
      if (duty != prev) begin
        changes++;
        if (first_it < 0) first_it = it;
        chk({name, "_boundary"}, int'(tb_cnt), 0);
`ifdef PWM_SCHED_RAMP_EN
        exp_step = (prev < target) ? prev + 4'd1 : prev - 4'd1;
`else
        exp_step = target;
`endif
        chk({name, "_step"}, int'(duty), int'(exp_step));
        prev = duty;
      end
      if (done) begin
        done_cnt++;
        if (done_it < 0) done_it = it;
        chk({name, "_busy_at_done"}, int'(busy), 0);
      end
      if (done_it >= 0 && it >= done_it + 20) break;
      tick();
    end
    chk({name, "_changes"}, changes, exp_changes);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_final_duty"}, int'(duty), int'(target));
    chk({name, "_busy_end"}, int'(busy), 0);
    if (exp_changes == 0) chk({name, "_done_latency"}, done_it, 0);
    if (exp_first_it >= 0) chk({name, "_first_change"}, first_it, exp_first_it);
    $display("txn %s start=%0d target=%0d changes=%0d done_pulses=%0d duty=%0d",
             name, start, target, changes, done_cnt, duty);
    model_duty = target;
  endtask

  initial begin
    int n;
    jobs[0] = '{2'b01, 4'd15, 4'd0,  2'b01, 4'd15};
    jobs[1] = '{2'b10, 4'd0,  4'd15, 2'b10, 4'd15};
    jobs[2] = '{2'b11, 4'd0,  4'd5,  2'b01, 4'd0};
    jobs[3] = '{2'b01, 4'd15, 4'd0,  2'b01, 4'd15};
    jobs[4] = '{2'b11, 4'd4,  4'd8,  2'b10, 4'd8};
    jobs[5] = '{2'b10, 4'd0,  4'd8,  2'b10, 4'd8};
    jobs[6] = '{2'b11, 4'd1,  4'd2,  2'b01, 4'd1};

    // Reset state
    req_valid = 2'b10;
    #3;
    chk("rst_ready_spi", int'(req_ready), 2);
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_period_start", int'(period_start), 0);
    req_valid = 2'b00;
    #1;
    chk("rst_ready_idle", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("period_start_idle", int'(period_start), (i % 16 == 0) ? 1 : 0);
    end
    chk("idle_duty", int'(duty), 0);
    chk("idle_busy", int'(busy), 0);
    $display("txn reset_idle period_start checked over 32 clocks");
    model_duty = 4'd0;

    // ALU requests 3 at cnt 5; first change lands at the next boundary
    sync_cnt(4'd5);
    apply(2'b01, 4'd3, 4'd0, 2'b01, "t_alu3");
    run_job("t_alu3", model_duty, 4'd3, 10);

    // Reach duty 6, accept 10, reset while the target is pending
    sync_cnt(4'd3);
    apply(2'b01, 4'd6, 4'd0, 2'b01, "t_to6");
    run_job("t_to6", model_duty, 4'd6, -1);
    sync_cnt(4'd3);
    apply(2'b01, 4'd10, 4'd0, 2'b01, "t_to10");
    tick();
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_duty", int'(duty), 6);
    #2;
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_duty", int'(duty), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ptr", int'(req_ready), 1);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (period_start) begin
        n = i;
        break;
      end
    end
    chk("post_rst_period_start", n, 16);
    $display("txn reset_mid_target first_period_start_after=%0d", n);
    model_duty = 4'd0;

    // Both valid: ALU wins first, SPI then replaces the pending target
    sync_cnt(4'd3);
    apply(2'b11, 4'd7, 4'd9, 2'b01, "t_both_alu");
    apply(2'b10, 4'd7, 4'd9, 2'b10, "t_both_spi");
    run_job("t_both", model_duty, 4'd9, -1);

    // Target replaced while waiting: only 12 is ever applied
    sync_cnt(4'd2);
    apply(2'b10, 4'd0, 4'd2, 2'b10, "t_rep_spi");
    apply(2'b01, 4'd12, 4'd0, 2'b01, "t_rep_alu");
    run_job("t_replace", model_duty, 4'd12, -1);

    // Table of single-cycle requests, started at various counter phases
    for (int i = 0; i < 7; i++) begin
      sync_cnt(4'((i * 5) % 16));
      chk("job_start_duty", int'(duty), int'(model_duty));
      apply(jobs[i].valid, jobs[i].d0, jobs[i].d1, jobs[i].exp_ready, $sformatf("job%0d", i));
      run_job($sformatf("job%0d", i), model_duty, jobs[i].exp_duty, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
